// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO sequencer for the EX stage: registered multiplier, 32-step restoring
// divider and MTHI/MTLO moves, each ending in a single-cycle HI/LO write pulse.
module hilo_muldiv_ctrl (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        hi_write_enable_o,
    output logic [31:0] hi_write_data_o,
    output logic        lo_write_enable_o,
    output logic [31:0] lo_write_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_RUN,
        S_DIV_FIX,
        S_DONE
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;    // remainder while dividing, product high half after MUL
    logic [31:0] lo_q, lo_d;    // dividend/quotient while dividing, multiplicand before MUL
    logic [31:0] dvs_q, dvs_d;  // divisor or multiplier
    logic [4:0]  cnt_q, cnt_d;
    logic        sa_q, sa_d;
    logic        sb_q, sb_d;

    logic        in_mul, in_div, in_mt;
    logic        a_neg, b_neg;
    logic        mul_sx;
    logic [63:0] prod;
    logic [32:0] shifted, diff;

    assign in_mul = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign in_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    assign in_mt  = (op_i == OP_MTHI) || (op_i == OP_MTLO);
    assign a_neg  = (op_i == OP_DIV) && opa_i[31];
    assign b_neg  = (op_i == OP_DIV) && opb_i[31];

    // Sign-extending to 64 bits and keeping the low 64 product bits gives the
    // exact signed result for MULT and the unsigned one for MULTU.
    assign mul_sx = (op_q == OP_MULT);
    assign prod   = {{32{mul_sx & lo_q[31]}}, lo_q} * {{32{mul_sx & dvs_q[31]}}, dvs_q};

    assign shifted = {hi_q, lo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            hi_q    <= 32'h0;
            lo_q    <= 32'h0;
            dvs_q   <= 32'h0;
            cnt_q   <= 5'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        hi_d              = hi_q;
        lo_d              = lo_q;
        dvs_d             = dvs_q;
        cnt_d             = cnt_q;
        sa_d              = sa_q;
        sb_d              = sb_q;
        busy_o            = 1'b0;
        hi_write_enable_o = 1'b0;
        hi_write_data_o   = 32'h0;
        lo_write_enable_o = 1'b0;
        lo_write_data_o   = 32'h0;

        case (state_q)
            S_IDLE: begin
                busy_o = op_valid_i && !flush_i && (in_mul || in_div);
                if (op_valid_i && !flush_i && (in_mul || in_div || in_mt)) begin
                    op_d = op_i;
                    if (in_mul) begin
                        state_d = S_MUL;
                        lo_d    = opa_i;
                        dvs_d   = opb_i;
                    end else if (in_div) begin
                        state_d = S_DIV_RUN;
                        hi_d    = 32'h0;
                        lo_d    = a_neg ? (~opa_i + 32'd1) : opa_i;
                        dvs_d   = b_neg ? (~opb_i + 32'd1) : opb_i;
                        sa_d    = a_neg;
                        sb_d    = b_neg;
                        cnt_d   = 5'd31;
                    end else begin
                        state_d = S_DONE;
                        hi_d    = opa_i;
                        lo_d    = opa_i;
                    end
                end
            end
            S_MUL: begin
                busy_o  = 1'b1;
                hi_d    = prod[63:32];
                lo_d    = prod[31:0];
                state_d = S_DONE;
            end
            S_DIV_RUN: begin
                busy_o = 1'b1;
                if (!diff[32]) begin
                    hi_d = diff[31:0];
                    lo_d = {lo_q[30:0], 1'b1};
                end else begin
                    hi_d = shifted[31:0];
                    lo_d = {lo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_DIV_FIX;
            end
            S_DIV_FIX: begin
                busy_o  = 1'b1;
                lo_d    = (sa_q ^ sb_q) ? (~lo_q + 32'd1) : lo_q;
                hi_d    = sa_q ? (~hi_q + 32'd1) : hi_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    hi_write_enable_o = (op_q != OP_MTLO);
                    lo_write_enable_o = (op_q != OP_MTHI);
                    hi_write_data_o   = (op_q != OP_MTLO) ? hi_q : 32'h0;
                    lo_write_data_o   = (op_q != OP_MTHI) ? lo_q : 32'h0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) state_d = S_IDLE;
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: expected writes are queued at issue
// and matched (data and cycle) against every write pulse the DUT produces.
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] opa, opb;
    logic        flush;
    logic        busy;
    logic        hi_en, lo_en;
    logic [31:0] hi_data, lo_data;

    hilo_muldiv_ctrl dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .op_valid_i        (op_valid),
        .op_i              (op),
        .opa_i             (opa),
        .opb_i             (opb),
        .flush_i           (flush),
        .busy_o            (busy),
        .hi_write_enable_o (hi_en),
        .hi_write_data_o   (hi_data),
        .lo_write_enable_o (lo_en),
        .lo_write_data_o   (lo_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        he;
        logic [31:0] hd;
        logic        le;
        logic [31:0] ld;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] p;
        logic [31:0] ma;
        sa  = $signed(a);
        sbv = $signed(b);
        case (o)
            3'b000: begin p = sa * sbv; return p; end
            3'b001: begin p = {32'h0, a} * {32'h0, b}; return p; end
            3'b010: begin
                if (b == 32'h0) begin
                    ma = a[31] ? (32'h0 - a) : a;
                    return {(a[31] ? (32'h0 - ma) : ma), (a[31] ? 32'h1 : 32'hFFFFFFFF)};
                end
                q = sa / sbv;
                r = sa % sbv;
                return {r[31:0], q[31:0]};
            end
            3'b011: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return {a, a};
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o[2]) return 1;
        if (o[1]) return 34;
        return 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op this cycle and queue the write it must produce.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m;
        m        = model(o, a, b);
        op_valid = 1'b1;
        op       = o;
        opa      = a;
        opb      = b;
        e.cyc    = cyc + lat_of(o);
        e.he     = (o != 3'b101);
        e.le     = (o != 3'b100);
        e.hd     = e.he ? m[63:32] : 32'h0;
        e.ld     = e.le ? m[31:0]  : 32'h0;
        sb.push_back(e);
    endtask

    // Hold the op through its DONE cycle, then let the pipeline move on.
    task automatic finish_op(input logic [2:0] o);
        repeat (lat_of(o)) tick();
        tick();
        op_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (hi_en === 1'b1 || lo_en === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write cyc=%0d got he=%b hd=%h le=%b ld=%h, want no write",
                         cyc, hi_en, hi_data, lo_en, lo_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.cyc || hi_en !== e.he || lo_en !== e.le ||
                    hi_data !== e.hd || lo_data !== e.ld) begin
                    miscompares++;
                    $display("FAIL write cyc=%0d he=%b hd=%h le=%b ld=%h, want cyc=%0d he=%b hd=%h le=%b ld=%h",
                             cyc, hi_en, hi_data, lo_en, lo_data, e.cyc, e.he, e.hd, e.le, e.ld);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op = 3'b000; opa = 32'h0; opb = 32'h0; flush = 1'b0;
        tick(); tick();
        @(negedge clk);
        vectors++;
        if ({busy, hi_en, lo_en, hi_data, lo_data} !== 67'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b he=%b le=%b hd=%h ld=%h, want all 0",
                     busy, hi_en, lo_en, hi_data, lo_data);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        issue(3'b001, 32'hFFFFFFFF, 32'h2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (k < 2)) begin
                miscompares++;
                $display("FAIL mul_busy T+%0d got %b want %b", k, busy, (k < 2));
            end
            tick();
        end
        op_valid = 1'b0;
        issue(3'b000, 32'hFFFFFFFD, 32'h5);
        finish_op(3'b000);
    endtask

    task automatic test_div();
        issue(3'b010, 32'hFFFFFFF9, 32'h2);
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== (k < 34)) begin
                miscompares++;
                $display("FAIL div_busy T+%0d got %b want %b", k, busy, (k < 34));
            end
            tick();
        end
        op_valid = 1'b0;
        issue(3'b011, 32'h7, 32'h0);
        finish_op(3'b011);
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        finish_op(3'b010);
        issue(3'b010, 32'hFFFFFFF9, 32'h0);
        finish_op(3'b010);
    endtask

    task automatic test_mt();
        issue(3'b101, 32'h12345678, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL mtlo_busy T+%0d got %b want 0", k, busy);
            end
            tick();
        end
        issue(3'b100, 32'hCAFEF00D, 32'h0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_busy got %b want 0", busy);
        end
        finish_op(3'b100);
    endtask

    task automatic test_flush();
        op_valid = 1'b1; op = 3'b010; opa = 32'h00001234; opb = 32'h7;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(3'b100, 32'hA5A5A5A5, 32'h0);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_busy got %b want 0", busy);
        end
        finish_op(3'b100);
        repeat (30) tick();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op = 3'b011; opa = 32'hDEADBEEF; opb = 32'h3;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, hi_en, lo_en, hi_data, lo_data} !== 67'h0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b he=%b le=%b hd=%h ld=%h, want all 0",
                     busy, hi_en, lo_en, hi_data, lo_data);
        end
        repeat (20) tick();
        op_valid = 1'b1; op = 3'b001; opa = 32'h3; opb = 32'h4;
        tick(); tick();
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (hi_en !== 1'b0 || lo_en !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_done got he=%b le=%b want 0 0", hi_en, lo_en);
        end
        tick();
        flush = 1'b0;
        op_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_undef();
        for (int k = 0; k < 4; k++) begin
            op_valid = 1'b1;
            op = (k < 2) ? 3'b110 : 3'b111;
            opa = 32'h11111111; opb = 32'h2;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL undef_busy op=%b got %b want 0", op, busy);
            end
            tick();
        end
        op_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int n = 0; n < 12; n++) begin
            o = 3'($urandom_range(0, 5));
            a = $urandom();
            b = (n % 5 == 4) ? 32'h0 : (($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(1, 300)));
            issue(o, a, b);
            @(negedge clk);
            vectors++;
            if (busy !== !o[2]) begin
                miscompares++;
                $display("FAIL b2b_busy op=%b got %b want %b", o, busy, !o[2]);
            end
            finish_op(o);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mt();
        test_flush();
        test_reset_mid();
        test_undef();
        test_back_to_back();
        repeat (5) tick();
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_write got none, want cyc=%0d hd=%h ld=%h", e.cyc, e.hd, e.ld);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
